// File: rtl/gcd_requester_if.sv
// gcd_requester_if: system-side request/response bundle for gcd_requester.
//
// Request channel : req_valid/req_ready handshake carrying operands req_a, req_b.
// Response channel: rsp_valid/rsp_ready handshake carrying rsp_gcd, rsp_timeout
//                   and, when GCD_REQ_CYCLE_COUNT_EN is defined, rsp_cycles.
//
// master : the producer/consumer driving requests and accepting responses.
// slave  : the requester itself.
interface gcd_requester_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_gcd;
  logic        rsp_timeout;
`ifdef GCD_REQ_CYCLE_COUNT_EN
  logic [15:0] rsp_cycles;
`endif

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_gcd, rsp_timeout
`ifdef GCD_REQ_CYCLE_COUNT_EN
    , input rsp_cycles
`endif
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_gcd, rsp_timeout
`ifdef GCD_REQ_CYCLE_COUNT_EN
    , output rsp_cycles
`endif
  );
endinterface

// File: rtl/gcd_requester.sv
// gcd_requester: host-side initiator for one gcd core.
//
// Accepts an operand pair on the request channel, holds the core in reset with
// the new operands for RESET_CYCLES cycles, releases it and waits for core_done
// (bounded by a TIMEOUT_CYCLES watchdog), then presents the captured result on
// the response channel until it is taken. Zero operands bypass the core.
//
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low
//   bus          : gcd_requester_if.slave (request/response handshakes)
//   core_num1/2  : operands to the core, stable from accept until response taken
//   core_reset   : active-high core reset; low only while waiting for the result
//   core_gcd_out : result from the core
//   core_done    : completion flag from the core, honoured only while waiting
//
// Optional feature: define GCD_REQ_CYCLE_COUNT_EN to add bus.rsp_cycles, the
// number of run cycles spent before the result was captured.
module gcd_requester #(
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  gcd_requester_if.slave bus,
  output logic [31:0]  core_num1,
  output logic [31:0]  core_num2,
  output logic         core_reset,
  input  logic [31:0]  core_gcd_out,
  input  logic         core_done
);

  localparam int LW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t        state;
  logic [LW-1:0] ld_cnt;
  logic [WW-1:0] wd_cnt;

`ifdef GCD_REQ_CYCLE_COUNT_EN
  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      bus.req_ready   <= 1'b1;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_gcd     <= '0;
      bus.rsp_timeout <= 1'b0;
      core_num1       <= '0;
      core_num2       <= '0;
      core_reset      <= 1'b1;
      ld_cnt          <= '0;
      wd_cnt          <= '0;
`ifdef GCD_REQ_CYCLE_COUNT_EN
      bus.rsp_cycles  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            core_num1     <= bus.req_a;
            core_num2     <= bus.req_b;
            bus.req_ready <= 1'b0;
            if (bus.req_a == 32'd0 || bus.req_b == 32'd0) begin
              // gcd(a,0)=a and gcd(0,0)=0, so OR-ing the operands is the answer
              bus.rsp_gcd     <= bus.req_a | bus.req_b;
              bus.rsp_timeout <= 1'b0;
              bus.rsp_valid   <= 1'b1;
`ifdef GCD_REQ_CYCLE_COUNT_EN
              bus.rsp_cycles  <= '0;
`endif
              state <= RESP;
            end else begin
              ld_cnt <= '0;
              state  <= LOAD;
            end
          end
        end

        LOAD: begin
          if (ld_cnt == LW'(RESET_CYCLES - 1)) begin
            core_reset <= 1'b0;
            wd_cnt     <= '0;
            state      <= RUN;
          end else begin
            ld_cnt <= ld_cnt + 1'b1;
          end
        end

        RUN: begin
          // done is checked first so it wins over a coincident timeout
          if (core_done) begin
            bus.rsp_gcd     <= core_gcd_out;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            core_reset      <= 1'b1;
`ifdef GCD_REQ_CYCLE_COUNT_EN
            bus.rsp_cycles  <= sat16(32'(wd_cnt));
`endif
            state <= RESP;
          end else if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
            bus.rsp_gcd     <= '0;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            core_reset      <= 1'b1;
`ifdef GCD_REQ_CYCLE_COUNT_EN
            bus.rsp_cycles  <= sat16(32'(TIMEOUT_CYCLES));
`endif
            state <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        RESP: begin
          // req_ready comes back only after the handshake edge, so a new
          // request can never be taken in the cycle the response completes
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_requester.sv
// tb_gcd_requester: self-checking bench for gcd_requester with a behavioural
// gcd core that answers a programmable number of cycles after release.
module tb_gcd_requester;
  localparam int RC = 3;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gcd_requester_if bus();
  logic [31:0] core_num1, core_num2, core_gcd_out;
  logic        core_reset, core_done;

  gcd_requester #(.RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .core_num1(core_num1), .core_num2(core_num2), .core_reset(core_reset),
    .core_gcd_out(core_gcd_out), .core_done(core_done)
  );

  int total = 0;
  int bad = 0;

  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // Behavioural core: done appears core_delay cycles after reset release
  // (core_delay < 0 means never); spur injects stray done pulses.
  int   core_delay = -1;
  int   run_cnt = 0;
  logic spur = 1'b0;
  logic model_done;
  always @(posedge clk) run_cnt <= core_reset ? 0 : run_cnt + 1;
  assign model_done   = !core_reset && core_delay >= 0 && run_cnt == core_delay;
  assign core_done    = model_done | spur;
  assign core_gcd_out = model_done ? ref_gcd(core_num1, core_num2) : 32'hDEADBEEF;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference model built from the rules: bypass on zero, core result if done
  // arrives within the watchdog window, otherwise a timeout response.
  task automatic predict(input logic [31:0] a, input logic [31:0] b, input int delay,
                         output logic [31:0] g, output logic to, output int lat, output int cyc);
    if (a == 0 || b == 0) begin
      g = a | b; to = 1'b0; lat = 1; cyc = 0;
    end else if (delay >= 0 && delay <= TO - 1) begin
      g = ref_gcd(a, b); to = 1'b0; lat = RC + delay + 2; cyc = delay;
    end else begin
      g = 32'd0; to = 1'b1; lat = RC + TO + 1; cyc = (TO > 65535) ? 65535 : TO;
    end
  endtask

  task automatic run_txn(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input int delay, input int hold, input logic spur_en,
                         input logic [31:0] eg, input logic et, input int el, input int ec);
    int   cyc;
    logic saw_run, stable, got;
    core_delay = delay;
    @(negedge clk);
    check({nm, ":req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_a = 32'hA5A5A5A5; bus.req_b = 32'h5A5A5A5A;
    cyc = 0; saw_run = 1'b0; stable = 1'b1; got = 1'b0;
    while (!got && cyc < RC + 4 * TO + 20) begin
      @(negedge clk);
      cyc++;
      if (!core_reset) saw_run = 1'b1;
      if (core_num1 !== a || core_num2 !== b) stable = 1'b0;
      if (bus.rsp_valid) got = 1'b1;
      spur = spur_en && !got && cyc == 1;
    end
    spur = 1'b0;
    check({nm, ":latency"}, got ? cyc : -1, el);
    if (!got) return;
    check({nm, ":rsp_gcd"}, bus.rsp_gcd, eg);
    check({nm, ":rsp_timeout"}, {31'd0, bus.rsp_timeout}, {31'd0, et});
`ifdef GCD_REQ_CYCLE_COUNT_EN
    check({nm, ":rsp_cycles"}, {16'd0, bus.rsp_cycles}, ec);
`else
    if (ec < 0) check({nm, ":rsp_cycles_arg"}, ec, 0);
`endif
    check({nm, ":core_used"}, {31'd0, saw_run}, {31'd0, (a != 0 && b != 0)});
    check({nm, ":operands_stable"}, {31'd0, stable}, 32'd1);
    check({nm, ":ready_in_resp"}, {31'd0, bus.req_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1; bus.req_a = 32'd5; bus.req_b = 32'd5;
      spur = spur_en && i == 0;
      @(negedge clk);
      check({nm, ":hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      check({nm, ":hold_gcd"}, bus.rsp_gcd, eg);
      check({nm, ":hold_ready"}, {31'd0, bus.req_ready}, 32'd0);
    end
    spur = 1'b0; bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({nm, ":valid_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({nm, ":ready_back"}, {31'd0, bus.req_ready}, 32'd1);
    check({nm, ":gcd_held"}, bus.rsp_gcd, eg);
    check({nm, ":not_accepted"}, core_num1, a);
  endtask

  typedef struct {
    logic [31:0] a, b;
    int          delay, hold;
    logic        spur;
    logic [31:0] g;
    logic        to;
    int          lat, cyc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [31:0] ra, rb, rg;
    logic        rt;
    int          rd, rl, rcy, m;
    logic        got;

    tbl[0]  = '{32'd161, 32'd14, 20, 0, 1'b0, 32'd7,  1'b0, RC + 22, 20};
    tbl[1]  = '{32'd0,   32'd48, 5,  0, 1'b0, 32'd48, 1'b0, 1, 0};
    tbl[2]  = '{32'd0,   32'd0,  5,  0, 1'b0, 32'd0,  1'b0, 1, 0};
    tbl[3]  = '{32'd48,  32'd0,  5,  1, 1'b0, 32'd48, 1'b0, 1, 0};
    tbl[4]  = '{32'd12,  32'd18, -1, 0, 1'b0, 32'd0,  1'b1, RC + TO + 1, TO};
    tbl[5]  = '{32'd27,  32'd36, 5, 10, 1'b0, 32'd9,  1'b0, RC + 7, 5};
    tbl[6]  = '{32'd17,  32'd17, 0,  0, 1'b0, 32'd17, 1'b0, RC + 2, 0};
    tbl[7]  = '{32'd21,  32'd6,  TO - 1, 0, 1'b0, 32'd3, 1'b0, RC + TO + 1, TO - 1};
    tbl[8]  = '{32'd21,  32'd6,  TO, 0, 1'b0, 32'd0,  1'b1, RC + TO + 1, TO};
    tbl[9]  = '{32'd35,  32'd49, 2,  2, 1'b1, 32'd7,  1'b0, RC + 4, 2};
    tbl[10] = '{32'd1,   32'hFFFFFFFF, 1, 0, 1'b0, 32'd1, 1'b0, RC + 3, 1};

    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;

    // Reset values
    #3 reset = 1'b0;
    #1;
    check("rst:req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst:rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst:rsp_gcd", bus.rsp_gcd, 32'd0);
    check("rst:rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
    check("rst:core_num1", core_num1, 32'd0);
    check("rst:core_reset", {31'd0, core_reset}, 32'd1);
`ifdef GCD_REQ_CYCLE_COUNT_EN
    check("rst:rsp_cycles", {16'd0, bus.rsp_cycles}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 11; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].delay, tbl[i].hold,
              tbl[i].spur, tbl[i].g, tbl[i].to, tbl[i].lat, tbl[i].cyc);

    // Reset in the middle of RUN: immediate reset values, no late response
    core_delay = -1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_a = 32'd100; bus.req_b = 32'd75;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (RC + 4) @(negedge clk);
    check("midrun:in_run", {31'd0, core_reset}, 32'd0);
    reset = 1'b0;
    #1;
    check("midrun:core_reset", {31'd0, core_reset}, 32'd1);
    check("midrun:req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("midrun:rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("midrun:rsp_gcd", bus.rsp_gcd, 32'd0);
    check("midrun:core_num1", core_num1, 32'd0);
    check("midrun:core_num2", core_num2, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    got = 1'b0;
    repeat (RC + TO + 5) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1'b1;
    end
    check("midrun:no_response", {31'd0, got}, 32'd0);
    run_txn("after_reset", 32'd100, 32'd75, 4, 0, 1'b0, 32'd25, 1'b0, RC + 6, 4);

    // Randomized transactions against the reference model
    for (int i = 0; i < 30; i++) begin
      m  = $urandom_range(1, 30);
      ra = ($urandom_range(0, 7) == 0) ? 32'd0 : m * $urandom_range(1, 400);
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : m * $urandom_range(1, 400);
      rd = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO + 3));
      predict(ra, rb, rd, rg, rt, rl, rcy);
      run_txn($sformatf("rnd%0d", i), ra, rb, rd, $urandom_range(0, 3),
              1'($urandom_range(0, 1)), rg, rt, rl, rcy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gcd_requester.md
# gcd_requester

Host-side initiator for the `gcd` core. It accepts operand pairs over a valid/ready request port, drives the core's `num1`/`num2`/`reset` inputs, and waits for `DONE`. It then captures `gcd_out` and returns the result over a valid/ready response port, guarded by a timeout watchdog. It sits between a system-side producer/consumer and one `gcd` instance, replacing the hand-driven stimulus used in bench bring-up.

## Interface
- `RESET_CYCLES`, default 2: cycles `core_reset` is held high with new operands before release (≥1).
- `TIMEOUT_CYCLES`, default 1024: maximum cycles spent waiting for `core_done` in RUN (≥2).
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request operands valid.
- `req_ready` out 1: requester can accept; equals (state==IDLE).
- `req_a` in 32: first operand.
- `req_b` in 32: second operand.
- `rsp_valid` out 1: result valid; held until `rsp_ready`.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_gcd` out 32: result; 0 on timeout.
- `rsp_timeout` out 1: result produced by watchdog, not core.
- `core_num1` out 32: to `gcd.num1`.
- `core_num2` out 32: to `gcd.num2`.
- `core_reset` out 1: to `gcd.reset`, active-high.
- `core_gcd_out` in 32: from `gcd.gcd_out`.
- `core_done` in 1: from `gcd.DONE`.

## Operation
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_gcd`=0, `rsp_timeout`=0, `core_num1`/`core_num2`=0, `core_reset`=1, counters 0.
- IDLE: `core_reset`=1. Accept on `req_valid && req_ready`; register `req_a`→`core_num1`, `req_b`→`core_num2`.
  - If either operand is 0, bypass the core and go to RESP with `rsp_gcd` = `req_a | req_b` (gcd(a,0)=a, gcd(0,0)=0), `rsp_timeout`=0.
  - Otherwise go to LOAD.
- LOAD: `core_reset`=1 for exactly `RESET_CYCLES` cycles, then RUN. Operands are stable from the accept edge until leaving RESP.
- RUN: `core_reset`=0; the watchdog counts from 0.
  - The first cycle `core_done`=1 is sampled: capture `core_gcd_out`→`rsp_gcd`, `rsp_timeout`=0, go to RESP.
  - If the count reaches `TIMEOUT_CYCLES-1` without `core_done`: `rsp_gcd`=0, `rsp_timeout`=1, go to RESP.
  - If `core_done` and timeout coincide, `core_done` wins.
- RESP: `rsp_valid`=1, `core_reset`=1 (core parked). On `rsp_ready`, `rsp_valid` drops next cycle and the state returns to IDLE. `rsp_gcd`/`rsp_timeout` hold their values until the next capture.
- Any `core_done` pulse outside RUN is ignored.
- A request is never accepted in the same cycle a response completes; `req_ready` rises the cycle after the RESP handshake.
- Async `reset` asserted in any state: immediate return to reset values. The in-flight operation is discarded with no response, and `core_reset` goes to 1 at once.

## Timing
- Accept edge N → LOAD cycles N+1..N+RESET_CYCLES → RUN from N+RESET_CYCLES+1.
- If the core raises `core_done` k cycles into RUN (k=0 is the first RUN cycle), `rsp_valid` rises at N+RESET_CYCLES+k+2.
- Zero bypass: `rsp_valid` high at N+1.
- Timeout: `rsp_valid` high at N+RESET_CYCLES+TIMEOUT_CYCLES+1.
- Minimum back-to-back request spacing: RESP handshake cycle + 1.
- Watchdog counter width: $clog2(TIMEOUT_CYCLES) bits; it does not wrap and saturates on the timeout compare.

## Configuration
- `GCD_REQ_CYCLE_COUNT_EN` defined: adds output `rsp_cycles` [15:0], the number of RUN cycles before capture (k above).
  - 0 on bypass; `TIMEOUT_CYCLES` (saturated at 16'hFFFF) on timeout.
  - Reset value 0; held with `rsp_gcd`.
- Macro undefined: port and counter absent; all other behaviour identical.

## Test plan
- Basic request, model core answering after 20 RUN cycles: req 161,14 with `rsp_ready`=1 → `rsp_gcd`=7, `rsp_timeout`=0, `rsp_valid` at accept+RESET_CYCLES+22; `rsp_cycles`=20 if enabled.
- Zero bypass: req 0,48 → 48 and req 0,0 → 0 at accept+1; `core_reset` never deasserts.
- Timeout: `core_done` stuck 0, req 12,18 → after RESET_CYCLES+TIMEOUT_CYCLES+1 cycles `rsp_timeout`=1, `rsp_gcd`=0.
- Backpressure: `rsp_ready`=0 for 10 cycles after result 9 (req 27,36) → `rsp_valid` and `rsp_gcd`=9 held stable, `req_ready`=0 throughout, and a `req_valid` presented meanwhile is not accepted.
- Reset mid-RUN: assert `reset`=0 during RUN of req 100,75 → all outputs at reset values the same cycle, no response after release. Next req 100,75 → 25.
- Spurious done: `core_done` pulsed during LOAD and RESP → ignored; results for the next requests are unaffected.
